// File: rtl/ame_equation_builder_pkg.sv
// Shared types, constants and helpers for the affine motion-estimation
// equation builder.
package ame_pkg;
  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, EMIT, WAIT} ame_state_e;

  localparam int AME_ROWS      = 6;
  localparam int AME_COLS      = 7;
  localparam int N4            = 4;
  localparam int N6            = 6;
  localparam int PARAM4_OFFSET = 2;
  // Wide enough for x*gx + y*gy with 16-bit gradients and 8-bit positions.
  localparam int COEF_BITS     = 32;
  localparam int NUM_A         = AME_ROWS * (AME_ROWS + 1) / 2;

  typedef logic [AME_ROWS-1:0][COEF_BITS-1:0] coef_vec_t;

  // Slot of A[i][j] in the packed upper triangle; argument order is irrelevant.
  function automatic int triIdx(input int i, input int j);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * AME_ROWS - (lo * (lo - 1)) / 2 + (hi - lo);
  endfunction
endpackage

// File: rtl/ame_equation_builder_coef_gen.sv
// First pipeline stage: forms the affine coefficient vector c[0..5] of one
// sample and registers it when the sample is accepted.
module ame_coef_gen
  import ame_pkg::*;
#(
  parameter int GRAD_BITS = 16,
  parameter int POS_BITS  = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        load_i,
  input  logic                        param6_i,
  input  logic signed [GRAD_BITS-1:0] grad_x_i,
  input  logic signed [GRAD_BITS-1:0] grad_y_i,
  input  logic        [POS_BITS-1:0]  pos_x_i,
  input  logic        [POS_BITS-1:0]  pos_y_i,
  output coef_vec_t                   coef_o
);

  coef_vec_t coef_q, coef_d;
  logic signed [COEF_BITS-1:0] gx, gy, px, py, xgx, xgy, ygx, ygy;

  always_comb begin
    gx  = COEF_BITS'(grad_x_i);
    gy  = COEF_BITS'(grad_y_i);
    px  = COEF_BITS'(pos_x_i);
    py  = COEF_BITS'(pos_y_i);
    xgx = px * gx;
    xgy = px * gy;
    ygx = py * gx;
    ygy = py * gy;
    // The 4-parameter model folds zoom and rotation into c[1] and c[3].
    if (param6_i) begin
      coef_d = {ygy, ygx, xgy, gy, xgx, gx};
    end else begin
      coef_d = {{COEF_BITS{1'b0}}, {COEF_BITS{1'b0}}, ygx - xgy, gy, xgx + ygy, gx};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      coef_q <= '0;
    end else if (load_i) begin
      coef_q <= coef_d;
    end
  end

  assign coef_o = coef_q;

endmodule

// File: rtl/ame_equation_builder.sv
// Accumulates one block of gradient/residual samples into the affine normal
// equations A*x = B and loads the 6x7 system into the solver row by row.
module ame_equation_builder
  import ame_pkg::*;
#(
  parameter int COMP_DATA_BITS = 64,
  parameter int GRAD_BITS      = 16,
  parameter int POS_BITS       = 8,
  parameter int RES_BITS       = 16
) (
  input  logic                                              clk_i,
  input  logic                                              rst_i,
  input  logic                                              sample_valid_i,
  output logic                                              sample_ready_o,
  input  logic                                              sample_last_i,
  input  logic                                              affine_param6_i,
  input  logic signed [GRAD_BITS-1:0]                       grad_x_i,
  input  logic signed [GRAD_BITS-1:0]                       grad_y_i,
  input  logic        [POS_BITS-1:0]                        pos_x_i,
  input  logic        [POS_BITS-1:0]                        pos_y_i,
  input  logic signed [RES_BITS-1:0]                        resid_i,
  output logic                                              comp_init_o,
  output logic [AME_ROWS-1:0][AME_COLS-1:0][COMP_DATA_BITS-1:0] comp_data_o,
  output logic [7:0]                                        comp_data_index_o,
  output logic                                              affine_param6_o,
  input  logic                                              comp_done_i
);

  ame_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] lastRow;
  logic       mode_q;
  logic       accept, firstBeat, coefParam6;
  logic       valid1_q, valid2_q;
  coef_vec_t  coef;
  logic signed [RES_BITS-1:0] resid_q;
  logic [COMP_DATA_BITS-1:0]  residExt;
  logic [AME_ROWS-1:0][COMP_DATA_BITS-1:0] coefExt, prodB_d, prodB_q, accB_q;
  logic [NUM_A-1:0][COMP_DATA_BITS-1:0]    prodA_d, prodA_q, accA_q;

  assign accept          = sample_valid_i & sample_ready_o;
  assign firstBeat       = accept & (state_q == IDLE);
  assign coefParam6      = (state_q == IDLE) ? affine_param6_i : mode_q;
  assign lastRow         = mode_q ? 3'(N6 - 1) : 3'(N4 - 1);
  assign affine_param6_o = mode_q;

  ame_coef_gen #(
    .GRAD_BITS(GRAD_BITS),
    .POS_BITS (POS_BITS)
  ) u_coef_gen (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (accept),
    .param6_i(coefParam6),
    .grad_x_i(grad_x_i),
    .grad_y_i(grad_y_i),
    .pos_x_i (pos_x_i),
    .pos_y_i (pos_y_i),
    .coef_o  (coef)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q times the pipeline drain and then walks the emitted rows.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, ACCUM: begin
        cnt_d = '0;
        if (accept) state_d = sample_last_i ? DRAIN : ACCUM;
      end
      DRAIN: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd2) begin
          state_d = EMIT;
          cnt_d   = '0;
        end
      end
      EMIT: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == lastRow) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (comp_done_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sample_ready_o    = 1'b0;
    comp_init_o       = 1'b0;
    comp_data_index_o = '0;
    case (state_q)
      IDLE, ACCUM: sample_ready_o = ~rst_i;
      EMIT: begin
        comp_init_o       = 1'b1;
        comp_data_index_o = 8'(cnt_q) + 8'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    coefExt  = '0;
    prodA_d  = '0;
    prodB_d  = '0;
    residExt = COMP_DATA_BITS'(resid_q);
    for (int i = 0; i < AME_ROWS; i++) begin
      coefExt[i] = COMP_DATA_BITS'($signed(coef[i]));
    end
    for (int i = 0; i < AME_ROWS; i++) begin
      for (int j = i; j < AME_ROWS; j++) begin
        prodA_d[triIdx(i, j)] = coefExt[i] * coefExt[j];
      end
      prodB_d[i] = coefExt[i] * residExt;
    end
  end

  // Accumulators are cleared by the first beat of a block, two edges before
  // that beat's products arrive, so the previous block's matrix stays visible
  // until then.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q   <= 1'b0;
      resid_q  <= '0;
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
      prodA_q  <= '0;
      prodB_q  <= '0;
      accA_q   <= '0;
      accB_q   <= '0;
    end else begin
      valid1_q <= accept;
      valid2_q <= valid1_q;
      if (accept) resid_q <= resid_i;
      if (valid1_q) begin
        prodA_q <= prodA_d;
        prodB_q <= prodB_d;
      end
      if (firstBeat) begin
        mode_q <= affine_param6_i;
        accA_q <= '0;
        accB_q <= '0;
      end else if (valid2_q) begin
        for (int k = 0; k < NUM_A; k++) accA_q[k] <= accA_q[k] + prodA_q[k];
        for (int k = 0; k < AME_ROWS; k++) accB_q[k] <= accB_q[k] + prodB_q[k];
      end
    end
  end

  // 4-parameter systems occupy physical rows/cols 2..5; rows/cols 0..1 read 0.
  always_comb begin
    comp_data_o = '0;
    for (int r = 0; r < AME_ROWS; r++) begin
      if (mode_q || r >= PARAM4_OFFSET) begin
        for (int c = 0; c < AME_ROWS; c++) begin
          if (mode_q) begin
            comp_data_o[r][c] = accA_q[triIdx(r, c)];
          end else if (c >= PARAM4_OFFSET) begin
            comp_data_o[r][c] = accA_q[triIdx(r - PARAM4_OFFSET, c - PARAM4_OFFSET)];
          end
        end
        comp_data_o[r][AME_COLS-1] = accB_q[mode_q ? r : r - PARAM4_OFFSET];
      end
    end
  end

endmodule

// File: doc/ame_equation_builder.md
Name: ame_equation_builder

Overview:
Producer side of the affine motion-estimation equation interface. Accumulates per-pixel gradient, position and residual samples of one block into the normal-equation system A·x = B (4- or 6-parameter affine). Then drives the 6x7 matrix into ame_equation_solver using its comp_init / comp_data_index load protocol, and holds until the solver reports done.

Parameters:
COMP_DATA_BITS, 64, matrix element width (two's complement)
GRAD_BITS, 16, signed gradient width (gx, gy)
POS_BITS, 8, unsigned pixel position width within block (x, y)
RES_BITS, 16, signed residual width (orig - pred)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
sample_valid_i  in  1  sample beat valid
sample_ready_o  out  1  builder accepts sample
sample_last_i  in  1  final sample of block
affine_param6_i  in  1  1 = 6-param, 0 = 4-param; sampled on first beat of block
grad_x_i  in  GRAD_BITS  signed horizontal gradient
grad_y_i  in  GRAD_BITS  signed vertical gradient
pos_x_i  in  POS_BITS  pixel x
pos_y_i  in  POS_BITS  pixel y
resid_i  in  RES_BITS  signed residual
comp_init_o  out  1  row-load strobe to solver
comp_data_o  out  6x7xCOMP_DATA_BITS  packed [5:0][6:0] matrix; column 6 = B
comp_data_index_o  out  8  row-load index
affine_param6_o  out  1  latched mode for solver
comp_done_i  in  1  solver finished

Behaviour:
- Reset: all outputs 0, sample_ready_o 0 during reset, 1 on the first cycle after; FSM to IDLE; accumulators cleared.
- Handshake: beat accepted when sample_valid_i & sample_ready_o. sample_ready_o = 1 only in IDLE/ACCUM.
- Coefficients c[0..5]:
  - 6-param: gx, x·gx, gy, x·gy, y·gx, y·gy.
  - 4-param: gx, x·gx+y·gy, gy, y·gx−x·gy.
  - All sign-extended to COMP_DATA_BITS.
- Pipeline: 3 stages.
  - S1: coefficients.
  - S2: products c[i]·c[j] for i≤j (21) and c[i]·resid (6).
  - S3: accumulate. Adds are modulo 2^COMP_DATA_BITS with no saturation; defaults guarantee no overflow for ≤16384 samples.
- Matrix mapping:
  - 6-param: logical k → physical row/col k.
  - 4-param: logical k → physical k+2; rows/cols 0–1 of comp_data_o are 0.
  - A stored symmetric; both halves driven. B[k] in column 6.
- FSM:
  - IDLE: first accepted beat clears accumulators, latches affine_param6_i into affine_param6_o, goes to ACCUM (or DRAIN if last).
  - ACCUM: accept beats; accepted beat with sample_last_i → DRAIN.
  - DRAIN: 3 cycles until pipeline empty → EMIT.
  - EMIT: comp_init_o = 1 for N cycles (N = 6 or 4), comp_data_index_o = 1..N; comp_data_o stable throughout → WAIT.
  - WAIT: comp_init_o = 0, comp_data_index_o = 0, matrix held. comp_done_i → IDLE.
- comp_done_i outside WAIT is ignored. Beats offered outside IDLE/ACCUM stall (ready low).
- sample_last_i on the first beat of a block gives a single-sample block.
- rst_i mid-block or mid-EMIT: next edge comp_init_o = 0, all state cleared, no partial row sequence resumed.
- Latency: last beat accepted at cycle t → comp_init_o first high at t+4.

Decomposition:
- Package ame_pkg:
  - FSM state enum {IDLE, ACCUM, DRAIN, EMIT, WAIT}
  - constants AME_ROWS=6, AME_COLS=7, N4=4, N6=6, PARAM4_OFFSET=2
  - coefficient vector typedef.
- Sub-module ame_coef_gen (S1 combinational + register): produces c[0..5] from gradients, position and mode.

Test Plan:
- 6-param single sample (gx=2, gy=3, x=4, y=5, d=7, last=1) → c=[2,8,3,12,10,15]; A00=4, A01=A10=16, A55=225, B0=14, B5=105; comp_init_o high 6 cycles, index 1..6, first high 4 cycles after beat.
- 4-param same sample → rows 2..5 used: A22=4, A33=529, A55=4, A35=A53=−46, B5=−14; row/col 0–1 zero; index 1..4; affine_param6_o=0.
- Two-beat 6-param block (above sample twice, second with last) → every element doubled (A00=8, B5=210); one EMIT sequence only.
- Stall/done: after EMIT hold comp_done_i low 20 cycles → sample_ready_o=0, matrix stable, extra comp_done_i pulses during EMIT ignored; pulse in WAIT → sample_ready_o=1 next cycle, next block's A00 excludes previous data.
- Reset mid-EMIT (rst_i at index 2) → next edge comp_init_o=0, comp_data_index_o=0, comp_data_o=0. A new single-sample block afterwards emits correct values.
- Extreme values: 16384 beats of gx=gy=−32768, x=y=255, 6-param → A00=2^44, A11=2^44·255², no wrap, results match the golden model.
